ball_launcher: RTL and testbench

Upstream stage of the scoring logic. Turns a player launch pulse into an animated ball that rolls back and forth across the 8 holes, slows down, and lands in one of them. It outputs a live one-hot position for the LED display. When the ball settles, it emits a one-cycle one-hot `ball` vector, which the score stage ANDs with the active hole mask.

---
 rtl/pinball_pkg.sv | 35 +++
 rtl/ball_launcher_if.sv | 31 +++
 rtl/lfsr8.sv | 21 ++
 rtl/ball_launcher.sv | 144 ++++++++++++++
 tb/tb_ball_launcher.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/pinball_pkg.sv
// Shared pinball types: launcher and game states, hole count,
// and the one-hot / LFSR helpers used by the launcher path.
package pinball_pkg;

  localparam int NUM_HOLES = 8;
  localparam int HOLE_W    = $clog2(NUM_HOLES);

  typedef logic [HOLE_W-1:0]    hole_t;
  typedef logic [NUM_HOLES-1:0] holes_t;

  typedef enum logic [1:0] {
    IDLE,
    ROLL,
    SETTLE,
    DONE
  } launch_state_t;

  typedef enum logic [2:0] {
    RESET,
    WAIT,
    START,
    GET,
    OVER
  } game_state_t;

  function automatic holes_t hole_onehot(hole_t h);
    return NUM_HOLES'(1) << h;
  endfunction

  // x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB
  function automatic logic [7:0] lfsr_next(logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

endpackage

// File: rtl/ball_launcher_if.sv
// Launcher-side bundle: animation/launch controls in,
// live position, landed-hole pulse and busy out.
interface ball_launcher_if;
  import pinball_pkg::*;

  logic   tick;
  logic   enable;
  logic   launch;
  holes_t ball_pos;
  holes_t ball;
  logic   busy;

  modport master (
    output tick,
    output enable,
    output launch,
    input  ball_pos,
    input  ball,
    input  busy
  );

  modport slave (
    input  tick,
    input  enable,
    input  launch,
    output ball_pos,
    output ball,
    output busy
  );

endinterface

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; reloads its seed only on rst.
// Shared by the launcher and later group selection.
module lfsr8
  import pinball_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SEED;
    end else begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/ball_launcher.sv
// Launch pulse to rolling, decelerating, bouncing ball;
// emits a one-cycle one-hot landed hole once it settles.
module ball_launcher
  import pinball_pkg::*;
#(
  parameter int         SETTLE_TICKS = 4,
  parameter int         MIN_STEPS    = 16,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  ball_launcher_if.slave   io
);

  localparam int SW = (SETTLE_TICKS < 1) ? 1
                    : $clog2(SETTLE_TICKS + 1);

  launch_state_t state;
  hole_t         pos;
  hole_t         next_pos;
  logic          dir_up;
  logic          next_up;
  logic [4:0]    steps;
  logic [4:0]    steps_load;
  logic [4:0]    moves;
  logic [4:0]    moves_inc;
  logic [3:0]    interval;
  logic [3:0]    reload;
  logic [SW-1:0] settle;
  holes_t        ball_pos_q;
  holes_t        ball_q;
  logic          busy_q;
  logic [7:0]    lfsr_q;
  logic          lfsr_unused;

  lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q[7:4];
  assign steps_load  = 5'(MIN_STEPS) + {1'b0, lfsr_q[3:0]};

  assign moves_inc = (moves == 5'd31) ? moves
                   : moves + 5'd1;

  // moves/4 of a 5-bit count tops out at 7, so the clamp is implicit
  assign reload = {1'b0, moves_inc[4:2]} + 4'd1;

  always_comb begin
    next_pos = pos;
    next_up  = dir_up;
    if (dir_up) begin
      if (pos == hole_t'(NUM_HOLES - 1)) begin
        next_pos = pos - hole_t'(1);
        next_up  = 1'b0;
      end else begin
        next_pos = pos + hole_t'(1);
      end
    end else begin
      if (pos == '0) begin
        next_pos = hole_t'(1);
        next_up  = 1'b1;
      end else begin
        next_pos = pos - hole_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pos        <= '0;
      dir_up     <= 1'b1;
      steps      <= '0;
      moves      <= '0;
      interval   <= '0;
      settle     <= '0;
      ball_pos_q <= hole_onehot('0);
      ball_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      ball_q <= '0;
      unique case (state)
        IDLE: begin
          if (io.launch && io.enable) begin
            state      <= (steps_load == '0) ? SETTLE : ROLL;
            steps      <= steps_load;
            pos        <= '0;
            dir_up     <= 1'b1;
            moves      <= '0;
            interval   <= 4'd1;
            settle     <= SW'(SETTLE_TICKS);
            ball_pos_q <= hole_onehot('0);
            busy_q     <= 1'b1;
          end
        end
        ROLL: begin
          if (io.tick) begin
            if (interval == 4'd1) begin
              pos        <= next_pos;
              dir_up     <= next_up;
              ball_pos_q <= hole_onehot(next_pos);
              steps      <= steps - 5'd1;
              moves      <= moves_inc;
              interval   <= reload;
              if (steps == 5'd1) begin
                state  <= SETTLE;
                settle <= SW'(SETTLE_TICKS);
              end
            end else begin
              interval <= interval - 4'd1;
            end
          end
        end
        SETTLE: begin
          if (io.tick) begin
            if (settle <= SW'(1)) begin
              state  <= DONE;
              ball_q <= ball_pos_q;
            end else begin
              settle <= settle - SW'(1);
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign io.ball_pos = ball_pos_q;
  assign io.ball     = ball_q;
  assign io.busy     = busy_q;

endmodule

// File: tb/tb_ball_launcher.sv
// Directed and random-phase launches against a hole/tick model,
// with a scoreboard queue of expected landed holes.
module tb_ball_launcher;

  localparam int MIN_STEPS    = 16;
  localparam int SETTLE_TICKS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ball_launcher_if bus ();

  ball_launcher #(
    .SETTLE_TICKS (SETTLE_TICKS),
    .MIN_STEPS    (MIN_STEPS),
    .LFSR_SEED    (8'hA5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  int tests    = 0;
  int fails    = 0;
  int pulses   = 0;
  int accepted = 0;
  int tick_cnt = 0;
  int tick_per = 1;
  int tick_ph  = 0;
  bit tick_on  = 1'b0;

  logic [7:0] m;
  logic [7:0] expq[$];
  logic [7:0] sb_exp;
  logic [7:0] prev_ball;
  logic [7:0] last_ball = 8'h00;
  logic       last_busy = 1'b0;
  logic       last_tick = 1'b0;

  always @(posedge clk)
    m <= rst ? 8'hA5 : {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int hole_of(input int s);
    int p;
    p = s % 14;
    return (p <= 7) ? p : 14 - p;
  endfunction

  function automatic int ticks_of(input int s);
    int t;
    int lvl;
    t = SETTLE_TICKS;
    for (int k = 1; k <= s; k++) begin
      lvl = (k - 1) / 4;
      t += 1 + ((lvl > 7) ? 7 : lvl);
    end
    return t;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.ball !== 8'h00) begin
      pulses++;
      chk("ball_onehot", 32'($onehot(bus.ball)), 1);
      chk("ball_width", prev_ball, 0);
      sb_exp = (expq.size() > 0) ? expq.pop_front() : 8'h00;
      chk("ball_hole", bus.ball, sb_exp);
    end
    prev_ball = bus.ball;
  end

  task automatic step();
    @(negedge clk);
    if (last_tick && last_busy && last_ball == 8'h00)
      tick_cnt++;
    last_busy = bus.busy;
    last_ball = bus.ball;
    tick_ph++;
    bus.tick  = tick_on && (tick_ph % tick_per == 0);
    last_tick = bus.tick;
  endtask

  task automatic launch_at(input int nib, input bit any,
                           output int s);
    int n;
    n = 0;
    while (!any && m[3:0] != nib[3:0] && n < 600) begin
      step();
      n++;
    end
    chk("nib_found", 32'(n < 600), 1);
    s = MIN_STEPS + int'(m[3:0]);
    expq.push_back(8'(1 << hole_of(s)));
    bus.enable = 1'b1;
    bus.launch = 1'b1;
    step();
    bus.launch = 1'b0;
    accepted++;
    tick_cnt = 0;
    chk("busy_accept", bus.busy, 1);
    chk("pos_accept", bus.ball_pos, 8'h01);
  endtask

  task automatic roll_to_done(input int exp_ticks,
                              input int relaunch_at,
                              input logic [7:0] exp_pos,
                              output bit b76, output bit b01,
                              output bit bad_adj);
    int n;
    logic [7:0] pp;
    n = 0;
    pp = bus.ball_pos;
    b76 = 0;
    b01 = 0;
    bad_adj = 0;
    while (bus.ball == 8'h00 && n < 2000) begin
      bus.launch = (n == relaunch_at);
      step();
      n++;
      if (bus.ball_pos != pp) begin
        if (pp == 8'h80 && bus.ball_pos == 8'h40) b76 = 1;
        if (b76 && pp == 8'h01 && bus.ball_pos == 8'h02) b01 = 1;
        if (bus.ball_pos != (pp << 1) && bus.ball_pos != (pp >> 1))
          bad_adj = 1;
        pp = bus.ball_pos;
      end
    end
    bus.launch = 1'b0;
    chk("done_timeout", 32'(n < 2000), 1);
    chk("roll_ticks", tick_cnt, exp_ticks);
    chk("land_pos", bus.ball_pos, exp_pos);
    step();
    chk("busy_done", bus.busy, 0);
    chk("ball_done", bus.ball, 0);
  endtask

  initial begin
    int s;
    int n;
    int p0;
    bit b76, b01, bad, idle_bad;

    bus.tick   = 1'b0;
    bus.enable = 1'b0;
    bus.launch = 1'b0;

    repeat (3) step();
    chk("rst_pos", bus.ball_pos, 8'h01);
    chk("rst_ball", bus.ball, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_lfsr", dut.u_lfsr.q, 8'hA5);
    rst = 1'b0;

    tick_on  = 1'b1;
    tick_per = 1;
    idle_bad = 0;
    repeat (20) begin
      step();
      if (bus.ball_pos !== 8'h01 || bus.ball !== 8'h00 || bus.busy !== 1'b0)
        idle_bad = 1;
    end
    chk("idle_stable", 32'(idle_bad), 0);

    bus.enable = 1'b0;
    bus.launch = 1'b1;
    step();
    bus.launch = 1'b0;
    step();
    chk("noen_busy", bus.busy, 0);
    chk("noen_pos", bus.ball_pos, 8'h01);

    tick_per = 2;
    launch_at(0, 0, s);
    roll_to_done(44, 5, 8'h04, b76, b01, bad);
    chk("adj16", 32'(bad), 0);

    launch_at(15, 0, s);
    roll_to_done(140, -1, 8'h08, b76, b01, bad);
    chk("bounce_76", 32'(b76), 1);
    chk("bounce_01", 32'(b01), 1);
    chk("adj31", 32'(bad), 0);

    launch_at(0, 0, s);
    n = 0;
    while (tick_cnt < 42 && n < 500) begin
      step();
      n++;
    end
    chk("settle_reach", 32'(n < 500), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_pos", bus.ball_pos, 8'h01);
    chk("mid_rst_ball", bus.ball, 0);
    chk("mid_rst_lfsr", dut.u_lfsr.q, 8'hA5);
    expq.delete();
    accepted--;
    p0 = pulses;
    repeat (40) step();
    chk("mid_rst_nopulse", pulses, p0);

    tick_per = 1;
    repeat (200) begin
      repeat ($urandom_range(0, 15)) step();
      launch_at(0, 1, s);
      roll_to_done(ticks_of(s), -1, 8'(1 << hole_of(s)),
                   b76, b01, bad);
    end

    repeat (5) step();
    chk("pulse_count", pulses, accepted);
    chk("queue_empty", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
